// File: rtl/m2_bus_sync.sv
// rtl/m2_bus_sync.sv - NES CPU bus synchronizer, M2 glitch filter and bus strobe generator
// Raw bus pins are double-flopped; M2 is debounced through a FILT_LEN-deep window.
module m2_bus_sync #(
  parameter int          FILT_LEN = 3,
  parameter logic [15:0] IDLE_TO  = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m2_raw,
  input  logic [15:0] cpu_addr_raw,
  input  logic [7:0]  cpu_dat_raw,
  input  logic        cpu_rw_raw,
  output logic        m2,
  output logic        m2_rise,
  output logic        m2_fall,
  output logic        rd_stb,
  output logic        wr_stb,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  wr_dat,
  output logic [15:0] m2_cnt,
  output logic        bus_idle
);

  localparam logic [1:0] ST_ARM  = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  // Edges after reset release before sh holds only real samples.
  localparam logic [3:0] FILL_MAX = 4'(FILT_LEN + 2);

  logic                m2_s1_q, m2_s1_d, m2_s2_q, m2_s2_d;
  logic [15:0]         addr_s1_q, addr_s1_d, addr_s2_q, addr_s2_d;
  logic [7:0]          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic                rw_s1_q, rw_s1_d, rw_s2_q, rw_s2_d;
  logic [FILT_LEN-1:0] sh_q, sh_d;
  logic [7:0]          dat_hold_q, dat_hold_d;
  logic [3:0]          fill_q, fill_d;
  logic [1:0]          state_q, state_d;
  logic                m2_q, m2_d, m2_rise_q, m2_rise_d, m2_fall_q, m2_fall_d;
  logic                rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
  logic [15:0]         bus_addr_q, bus_addr_d;
  logic                bus_rw_q, bus_rw_d;
  logic [7:0]          wr_dat_q, wr_dat_d;
  logic [15:0]         m2_cnt_q, m2_cnt_d;
  logic [15:0]         idle_cnt_q, idle_cnt_d;
  logic                sh_ones, sh_zeros;

  assign sh_ones  = &sh_q;
  assign sh_zeros = ~|sh_q;

  always_comb begin
    m2_s1_d    = m2_raw;
    m2_s2_d    = m2_s1_q;
    addr_s1_d  = cpu_addr_raw;
    addr_s2_d  = addr_s1_q;
    dat_s1_d   = cpu_dat_raw;
    dat_s2_d   = dat_s1_q;
    rw_s1_d    = cpu_rw_raw;
    rw_s2_d    = rw_s1_q;
    sh_d       = {sh_q[FILT_LEN-2:0], m2_s2_q};
    dat_hold_d = m2_s2_q ? dat_s2_q : dat_hold_q;
    fill_d     = (fill_q == FILL_MAX) ? fill_q : fill_q + 4'd1;
    state_d    = state_q;
    m2_d       = m2_q;
    m2_rise_d  = 1'b0;
    m2_fall_d  = 1'b0;
    rd_stb_d   = 1'b0;
    wr_stb_d   = 1'b0;
    bus_addr_d = bus_addr_q;
    bus_rw_d   = bus_rw_q;
    wr_dat_d   = wr_dat_q;
    m2_cnt_d   = m2_cnt_q;

    case (state_q)
      // Wait for a genuine low window so a cycle cut by reset is never strobed.
      ST_ARM: begin
        if (sh_zeros && fill_q == FILL_MAX) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (sh_ones) begin
          state_d    = ST_HIGH;
          m2_d       = 1'b1;
          m2_rise_d  = 1'b1;
          bus_addr_d = addr_s2_q;
          bus_rw_d   = rw_s2_q;
          rd_stb_d   = rw_s2_q;
        end
      end
      ST_HIGH: begin
        if (sh_zeros) begin
          state_d   = ST_LOW;
          m2_d      = 1'b0;
          m2_fall_d = 1'b1;
          m2_cnt_d  = m2_cnt_q + 16'd1;
          if (!bus_rw_q) begin
            wr_stb_d = 1'b1;
            wr_dat_d = dat_hold_q;
          end
        end
      end
      default: state_d = ST_ARM;
    endcase

    if (m2_fall_d)                 idle_cnt_d = 16'd0;
    else if (idle_cnt_q < IDLE_TO) idle_cnt_d = idle_cnt_q + 16'd1;
    else                           idle_cnt_d = idle_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_s1_q    <= 1'b0;
      m2_s2_q    <= 1'b0;
      addr_s1_q  <= 16'd0;
      addr_s2_q  <= 16'd0;
      dat_s1_q   <= 8'd0;
      dat_s2_q   <= 8'd0;
      rw_s1_q    <= 1'b0;
      rw_s2_q    <= 1'b0;
      sh_q       <= '0;
      dat_hold_q <= 8'd0;
      fill_q     <= 4'd0;
      state_q    <= ST_ARM;
      m2_q       <= 1'b0;
      m2_rise_q  <= 1'b0;
      m2_fall_q  <= 1'b0;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      bus_addr_q <= 16'd0;
      bus_rw_q   <= 1'b0;
      wr_dat_q   <= 8'd0;
      m2_cnt_q   <= 16'd0;
      idle_cnt_q <= 16'd0;
    end else begin
      m2_s1_q    <= m2_s1_d;
      m2_s2_q    <= m2_s2_d;
      addr_s1_q  <= addr_s1_d;
      addr_s2_q  <= addr_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      rw_s1_q    <= rw_s1_d;
      rw_s2_q    <= rw_s2_d;
      sh_q       <= sh_d;
      dat_hold_q <= dat_hold_d;
      fill_q     <= fill_d;
      state_q    <= state_d;
      m2_q       <= m2_d;
      m2_rise_q  <= m2_rise_d;
      m2_fall_q  <= m2_fall_d;
      rd_stb_q   <= rd_stb_d;
      wr_stb_q   <= wr_stb_d;
      bus_addr_q <= bus_addr_d;
      bus_rw_q   <= bus_rw_d;
      wr_dat_q   <= wr_dat_d;
      m2_cnt_q   <= m2_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign m2       = m2_q;
  assign m2_rise  = m2_rise_q;
  assign m2_fall  = m2_fall_q;
  assign rd_stb   = rd_stb_q;
  assign wr_stb   = wr_stb_q;
  assign bus_addr = bus_addr_q;
  assign bus_rw   = bus_rw_q;
  assign wr_dat   = wr_dat_q;
  assign m2_cnt   = m2_cnt_q;
  assign bus_idle = (idle_cnt_q == IDLE_TO);

endmodule

// File: tb/tb_m2_bus_sync.sv
// tb/tb_m2_bus_sync.sv - directed and randomized bus cycles against an edge-indexed bus model
module tb_m2_bus_sync;
  localparam int F    = 3;
  localparam int TO   = 100;
  localparam int NCYC = 40000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m2_raw;
  logic [15:0] cpu_addr_raw;
  logic [7:0]  cpu_dat_raw;
  logic        cpu_rw_raw;
  logic        m2, m2_rise, m2_fall, rd_stb, wr_stb, bus_rw, bus_idle;
  logic [15:0] bus_addr, m2_cnt;
  logic [7:0]  wr_dat;

  m2_bus_sync #(.FILT_LEN(F), .IDLE_TO(16'(TO))) dut (
    .clk(clk), .rst_n(rst_n), .m2_raw(m2_raw), .cpu_addr_raw(cpu_addr_raw),
    .cpu_dat_raw(cpu_dat_raw), .cpu_rw_raw(cpu_rw_raw), .m2(m2), .m2_rise(m2_rise),
    .m2_fall(m2_fall), .rd_stb(rd_stb), .wr_stb(wr_stb), .bus_addr(bus_addr),
    .bus_rw(bus_rw), .wr_dat(wr_dat), .m2_cnt(m2_cnt), .bus_idle(bus_idle)
  );

  always #5 clk = ~clk;

  // Raw pin values as seen at each clock edge, indexed by edge number.
  logic        h_m2   [NCYC];
  logic [15:0] h_addr [NCYC];
  logic [7:0]  h_dat  [NCYC];
  logic        h_rw   [NCYC];
  int t  = -1;
  int ep = 0;

  bit          armed, lvl, e_rise, e_fall, e_rd, e_wr, e_rw;
  logic [15:0] e_addr, e_cnt;
  logic [7:0]  e_wdat, hold;
  int          idle;
  int n_checks = 0, n_fail = 0;
  int n_rise_seen = 0, n_wr_seen = 0, rise_t = 0, raw_rise_t = 0;

  function automatic logic smp_m2(int i);
    return (i >= ep && i >= 0) ? h_m2[i] : 1'b0;
  endfunction
  function automatic logic [15:0] smp_addr(int i);
    return (i >= ep && i >= 0) ? h_addr[i] : 16'd0;
  endfunction
  function automatic logic [7:0] smp_dat(int i);
    return (i >= ep && i >= 0) ? h_dat[i] : 8'd0;
  endfunction
  function automatic logic smp_rw(int i);
    return (i >= ep && i >= 0) ? h_rw[i] : 1'b0;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic model_clear();
    armed = 0; lvl = 0; e_rise = 0; e_fall = 0; e_rd = 0; e_wr = 0; e_rw = 0;
    e_addr = '0; e_cnt = '0; e_wdat = '0; hold = '0; idle = 0;
  endtask

  // A filtered edge at edge t is decided by raw samples t-2-F .. t-3 all agreeing.
  task automatic model_edge();
    bit ones, zeros;
    e_rise = 0; e_fall = 0; e_rd = 0; e_wr = 0;
    if (!rst_n) begin
      model_clear();
      ep = t + 1;
      return;
    end
    ones = 1; zeros = 1;
    for (int i = 3; i <= F + 2; i++) begin
      if (smp_m2(t - i)) zeros = 0;
      else ones = 0;
    end
    if (!armed) begin
      if (zeros && (t - 2 - F) >= ep) armed = 1;
    end else if (!lvl && ones) begin
      lvl = 1; e_rise = 1;
      e_addr = smp_addr(t - 2);
      e_rw = smp_rw(t - 2);
      e_rd = e_rw;
    end else if (lvl && zeros) begin
      lvl = 0; e_fall = 1;
      e_cnt = e_cnt + 16'd1;
      if (!e_rw) begin
        e_wr = 1;
        e_wdat = hold;
      end
    end
    if (smp_m2(t - 2)) hold = smp_dat(t - 2);
    idle = e_fall ? 0 : ((idle < TO) ? idle + 1 : TO);
  endtask

  task automatic step();
    @(posedge clk);
    t++;
    if (t >= NCYC) begin
      $display("FAIL history overflow at edge %0d", t);
      $fatal(1);
    end
    h_m2[t] = m2_raw; h_addr[t] = cpu_addr_raw; h_dat[t] = cpu_dat_raw; h_rw[t] = cpu_rw_raw;
    model_edge();
    #1;
    check("m2", 16'(m2), 16'(lvl));
    check("m2_rise", 16'(m2_rise), 16'(e_rise));
    check("m2_fall", 16'(m2_fall), 16'(e_fall));
    check("rd_stb", 16'(rd_stb), 16'(e_rd));
    check("wr_stb", 16'(wr_stb), 16'(e_wr));
    check("bus_addr", bus_addr, e_addr);
    check("bus_rw", 16'(bus_rw), 16'(e_rw));
    check("wr_dat", 16'(wr_dat), 16'(e_wdat));
    check("m2_cnt", m2_cnt, e_cnt);
    check("bus_idle", 16'(bus_idle), 16'(idle == TO));
    if (m2_rise) begin n_rise_seen++; rise_t = t; end
    if (wr_stb) n_wr_seen++;
    if (m2_fall) check("idle_clear_at_fall", 16'(bus_idle), 16'd0);
  endtask

  task automatic hold_m2(input logic v, input int n);
    m2_raw = v;
    repeat (n) begin cpu_dat_raw = 8'($urandom); step(); end
  endtask

  // Data is only stable over the last 6 high clocks of a write; otherwise it is noise.
  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                           input int lo, input int hi);
    cpu_addr_raw = a; cpu_rw_raw = rw;
    hold_m2(1'b0, lo);
    m2_raw = 1'b1;
    raw_rise_t = t + 1;
    for (int i = 0; i < hi; i++) begin
      cpu_dat_raw = (!rw && i >= hi - 6) ? d : 8'($urandom);
      step();
    end
    m2_raw = 1'b0;
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0; m2_raw = 1'b0; cpu_addr_raw = '0; cpu_dat_raw = '0; cpu_rw_raw = 1'b0;
    repeat (3) step();
    #1;
    rst_n = 1'b1;

    bus_cycle(16'h8123, 8'h00, 1'b1, 10, 14);
    check("rd_latency", 16'(rise_t - raw_rise_t), 16'(F + 2));
    check("rd_bus_addr", bus_addr, 16'h8123);
    check("rd_bus_rw", 16'(bus_rw), 16'd1);
    hold_m2(1'b0, 10);
    check("rd_no_wr", 16'(n_wr_seen), 16'd0);

    bus_cycle(16'hC000, 8'h03, 1'b0, 4, 14);
    hold_m2(1'b0, 8);
    check("wr_count", 16'(n_wr_seen), 16'd1);
    check("wr_dat_c000", 16'(wr_dat), 16'h0003);
    check("wr_addr_c000", bus_addr, 16'hC000);
    check("wr_m2_cnt", m2_cnt, 16'd2);

    hold_m2(1'b1, 1); hold_m2(1'b0, 6);
    hold_m2(1'b1, 2); hold_m2(1'b0, 6);
    check("glitch_low_cnt", m2_cnt, 16'd2);
    cpu_rw_raw = 1'b1; cpu_addr_raw = 16'h4016;
    hold_m2(1'b1, 10);
    hold_m2(1'b0, 1); hold_m2(1'b1, 6);
    hold_m2(1'b0, 2); hold_m2(1'b1, 6);
    hold_m2(1'b0, 10);
    check("glitch_rise_count", 16'(n_rise_seen), 16'd3);
    check("glitch_high_cnt", m2_cnt, 16'd3);

    rst_n = 1'b0; m2_raw = 1'b1; cpu_rw_raw = 1'b0;
    n_rise_seen = 0; n_wr_seen = 0;
    repeat (3) step();
    #1;
    rst_n = 1'b1;
    hold_m2(1'b1, 12);
    hold_m2(1'b0, 2);
    hold_m2(1'b1, 8);
    check("arm_no_rise", 16'(n_rise_seen), 16'd0);
    check("arm_no_wr", 16'(n_wr_seen), 16'd0);
    hold_m2(1'b0, 10);
    bus_cycle(16'h6000, 8'h5A, 1'b0, 2, 12);
    hold_m2(1'b0, 8);
    check("arm_then_rise", 16'(n_rise_seen), 16'd1);
    check("arm_then_wr", 16'(n_wr_seen), 16'd1);
    check("arm_wr_dat", 16'(wr_dat), 16'h005A);

    hold_m2(1'b0, 150);
    check("idle_set", 16'(bus_idle), 16'd1);
    bus_cycle(16'h8000, 8'h11, 1'b1, 2, 10);
    hold_m2(1'b0, 8);
    check("idle_cleared", 16'(bus_idle), 16'd0);

    bus_cycle(16'hE000, 8'h77, 1'b0, 6, 8);
    m2_raw = 1'b1;
    step();
    rst_n = 1'b0;
    n_wr_seen = 0;
    #1;
    check("rst_m2", 16'(m2), 16'd0);
    check("rst_bus_addr", bus_addr, 16'd0);
    check("rst_m2_cnt", m2_cnt, 16'd0);
    check("rst_wr_dat", 16'(wr_dat), 16'd0);
    check("rst_bus_rw", 16'(bus_rw), 16'd0);
    hold_m2(1'b1, 2);
    hold_m2(1'b0, 2);
    rst_n = 1'b1;
    hold_m2(1'b0, 20);
    check("rst_no_wr", 16'(n_wr_seen), 16'd0);

    repeat (1200) begin
      bus_cycle(16'($urandom), 8'($urandom), 1'($urandom),
                ($urandom_range(0, 15) == 0) ? $urandom_range(20, 130) : $urandom_range(1, 12),
                $urandom_range(1, 12));
    end
    hold_m2(1'b0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
